// File: rtl/sum_unit_arbiter.sv
// ---------------------------------------------------------------------------
// sum_unit_arbiter
//
// Purpose:
//   Shares one four-byte-sum unit among NUM_REQ requesters. A round-robin
//   arbiter picks one requester at a time, hands its 32-bit word to the sum
//   unit through a start/data handshake, and returns the 10-bit result
//   tagged with the requester id. A unit that never answers is aborted
//   after TIMEOUT_CYCLES cycles and reported with an error response.
//
// Ports:
//   clk          - clock, rising edge
//   async_reset  - asynchronous, active-high reset
//   req          - per-requester request level
//   req_data     - word for requester i at bits [32i+31:32i]
//   ack          - one-cycle pulse to the served requester
//   rsp_valid    - one-cycle response strobe
//   rsp_id       - id of the served requester
//   rsp_data     - sum result, 0 on timeout
//   rsp_err      - high with rsp_valid when the request timed out
//   sum_start    - start level to the sum unit
//   sum_data     - operand word to the sum unit
//   sum_valid    - result-valid from the sum unit
//   sum_result   - result from the sum unit
//   busy         - high whenever the arbiter is not idle
//   timeout_err  - sticky timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module sum_unit_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   async_reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [32*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [9:0]             rsp_data,
    output logic                   rsp_err,
    output logic                   sum_start,
    output logic [31:0]            sum_data,
    input  logic                   sum_valid,
    input  logic [9:0]             sum_result,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_RESP,
        S_GAP
    } state_t;

    state_t                 r_state;
    logic [ID_W-1:0]        r_last;
    logic [ID_W-1:0]        r_id;
    logic [CNT_W-1:0]       r_count;
    logic [NUM_REQ-1:0]     r_ack;
    logic                   r_rspValid;
    logic [ID_W-1:0]        r_rspId;
    logic [9:0]             r_rspData;
    logic                   r_rspErr;
    logic                   r_sumStart;
    logic [31:0]            r_sumData;
    logic                   r_busy;
    logic                   r_timeoutErr;

    logic [2*NUM_REQ-1:0]   w_dbl;
    logic [NUM_REQ-1:0]     w_rot;
    logic                   w_found;
    int                     w_offset;
    int                     w_pos;
    logic [ID_W-1:0]        w_winner;
    logic [32*NUM_REQ-1:0]  w_shift;
    logic [31:0]            w_word;

    // Rotate the request vector so that bit 0 is the requester just after
    // the last winner. The pointer is widened by one bit before the +1 so
    // that wrapping past the top id cannot overflow the shift amount.
    assign w_dbl = {req, req} >> ({1'b0, r_last} + 1'b1);
    assign w_rot = w_dbl[NUM_REQ-1:0];

    // First set bit in the rotated vector wins; its offset is mapped back
    // to a real requester id with a single wrap, since last+1+offset never
    // exceeds 2*NUM_REQ-1.
    always_comb begin
        w_found  = 1'b0;
        w_offset = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found  = 1'b1;
                w_offset = k;
            end
        end
        w_pos = int'(r_last) + 1 + w_offset;
        if (w_pos >= NUM_REQ) begin
            w_pos = w_pos - NUM_REQ;
        end
        w_winner = ID_W'(w_pos);
    end

    // Winner's operand word, selected by shifting the flat data bus.
    assign w_shift = req_data >> {w_winner, 5'b00000};
    assign w_word  = w_shift[31:0];

    // Main control: grant in IDLE, wait for the unit (or the timeout) in
    // RUN, strobe the response on entry to RESP, then spend one GAP cycle
    // with start low so the unit sees a clean low between jobs.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_state      <= S_IDLE;
            r_last       <= ID_W'(NUM_REQ - 1);
            r_id         <= '0;
            r_count      <= '0;
            r_ack        <= '0;
            r_rspValid   <= 1'b0;
            r_rspId      <= '0;
            r_rspData    <= '0;
            r_rspErr     <= 1'b0;
            r_sumStart   <= 1'b0;
            r_sumData    <= '0;
            r_busy       <= 1'b0;
            r_timeoutErr <= 1'b0;
        end else begin
            r_ack      <= '0;
            r_rspValid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_id       <= w_winner;
                        r_last     <= w_winner;
                        r_sumStart <= 1'b1;
                        r_sumData  <= w_word;
                        r_count    <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    // A result on the limit cycle still counts as a success.
                    if (sum_valid || (r_count == CNT_LIMIT)) begin
                        if (sum_valid) begin
                            r_rspData <= sum_result;
                            r_rspErr  <= 1'b0;
                        end else begin
                            r_rspData    <= '0;
                            r_rspErr     <= 1'b1;
                            r_timeoutErr <= 1'b1;
                        end
                        r_sumStart <= 1'b0;
                        r_rspValid <= 1'b1;
                        r_ack      <= NUM_REQ'(1) << r_id;
                        r_rspId    <= r_id;
                        r_state    <= S_RESP;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_GAP;
                end
                S_GAP: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack         = r_ack;
    assign rsp_valid   = r_rspValid;
    assign rsp_id      = r_rspId;
    assign rsp_data    = r_rspData;
    assign rsp_err     = r_rspErr;
    assign sum_start   = r_sumStart;
    assign sum_data    = r_sumData;
    assign busy        = r_busy;
    assign timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_sum_unit_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sum_unit_arbiter
//
// Purpose:
//   Self-checking bench for sum_unit_arbiter. A behavioural sum unit answers
//   a programmable number of cycles after start rises (or never), and a
//   round-robin reference model predicts the winner and result of each job.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_sum_unit_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic              clk;
    logic              async_reset;
    logic [N-1:0]      req;
    logic [32*N-1:0]   req_data;
    logic [N-1:0]      ack;
    logic              rsp_valid;
    logic [IW-1:0]     rsp_id;
    logic [9:0]        rsp_data;
    logic              rsp_err;
    logic              sum_start;
    logic [31:0]       sum_data;
    logic              sum_valid;
    logic [9:0]        sum_result;
    logic              busy;
    logic              timeout_err;

    int checks   = 0;
    int failures = 0;

    int unitLatency = 3;
    bit unitEnable  = 1'b1;
    bit idlePulse   = 1'b0;
    bit unitBusy    = 1'b0;
    int unitWait    = 0;

    sum_unit_arbiter #(
        .NUM_REQ(N),
        .ID_W(IW),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk),
        .async_reset(async_reset),
        .req(req),
        .req_data(req_data),
        .ack(ack),
        .rsp_valid(rsp_valid),
        .rsp_id(rsp_id),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .sum_start(sum_start),
        .sum_data(sum_data),
        .sum_valid(sum_valid),
        .sum_result(sum_result),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    // 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference arithmetic: sum of the four bytes of a word.
    function automatic logic [9:0] byteSum(input logic [31:0] w);
        return 10'(w[7:0]) + 10'(w[15:8]) + 10'(w[23:16]) + 10'(w[31:24]);
    endfunction

    // Behavioural sum unit: after start is first seen high it waits
    // unitLatency cycles and pulses sum_valid for one cycle with the byte
    // sum of whatever sum_data it was given. idlePulse injects a stray
    // sum_valid pulse regardless of state.
    initial begin
        sum_valid  = 1'b0;
        sum_result = '0;
        forever begin
            @(negedge clk);
            sum_valid = idlePulse;
            if (idlePulse) sum_result = 10'h155;
            idlePulse = 1'b0;
            if (!sum_start) begin
                unitBusy = 1'b0;
            end else begin
                if (!unitBusy) begin
                    unitBusy = 1'b1;
                    unitWait = unitLatency;
                end
                if (unitWait > 0) begin
                    unitWait--;
                    if (unitWait == 0 && unitEnable) begin
                        sum_valid  = 1'b1;
                        sum_result = byteSum(sum_data);
                    end
                end
            end
        end
    end

    // Hang guard.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic doReset();
        async_reset = 1'b1;
        req         = '0;
        req_data    = '0;
        unitEnable  = 1'b1;
        unitLatency = 3;
        repeat (2) @(negedge clk);
        async_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic waitStart(input int budget, output bit got);
        int n;
        got = 1'b0;
        n   = 0;
        while (!got && n < budget) begin
            @(negedge clk);
            n++;
            if (sum_start) got = 1'b1;
        end
    endtask

    task automatic waitRsp(input int budget, output bit got, output int cycles, output int lowCycles);
        got       = 1'b0;
        cycles    = 0;
        lowCycles = 0;
        while (!got && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (!sum_start) lowCycles++;
            if (rsp_valid) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        async_reset = 1'b1;
        req         = '0;
        req_data    = '0;
        @(negedge clk);
        checks++;
        if ({ack, rsp_valid, rsp_id, rsp_data, rsp_err, sum_start, sum_data, busy, timeout_err} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: ack=%b rv=%b id=%0d data=%h err=%b start=%b sdata=%h busy=%b terr=%b, required all 0",
                     ack, rsp_valid, rsp_id, rsp_data, rsp_err, sum_start, sum_data, busy, timeout_err);
        end
        async_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_job();
        bit got;
        int cyc, low;
        doReset();
        req_data[31:0] = 32'h0302_0201;
        req            = 4'b0001;
        waitStart(10, got);
        checks++;
        if (!got || sum_data !== 32'h0302_0201 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_start: started=%b sum_data=%h busy=%b, required 1 03020201 1", got, sum_data, busy);
        end
        waitRsp(50, got, cyc, low);
        checks++;
        if (!got || cyc != 3) begin
            failures++;
            $display("[TB] FAIL single_latency: got=%b cycles=%0d, required 1 3", got, cyc);
        end
        checks++;
        if (rsp_id !== 2'd0 || rsp_data !== 10'h008 || rsp_err !== 1'b0 || ack !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL single_rsp: id=%0d data=%h err=%b ack=%b, required 0 008 0 0001", rsp_id, rsp_data, rsp_err, ack);
        end
        req = '0;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0000 || rsp_valid !== 1'b0 || rsp_data !== 10'h008) begin
            failures++;
            $display("[TB] FAIL single_pulse: ack=%b rv=%b data=%h, required 0000 0 008", ack, rsp_valid, rsp_data);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_max_value();
        bit got;
        int cyc, low;
        doReset();
        req_data[95:64] = 32'hFFFF_FFFF;
        req             = 4'b0100;
        waitRsp(50, got, cyc, low);
        checks++;
        if (!got || rsp_id !== 2'd2 || rsp_data !== 10'h3FC || ack !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL max_value: got=%b id=%0d data=%h ack=%b, required 1 2 3fc 0100", got, rsp_id, rsp_data, ack);
        end
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_fairness();
        bit got;
        int cyc, low;
        int exp;
        doReset();
        for (int i = 0; i < N; i++) req_data[32*i +: 32] = 32'h0101_0101;
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            exp = j % N;
            waitRsp(50, got, cyc, low);
            checks++;
            if (!got || rsp_id !== IW'(exp) || rsp_data !== 10'h004 || ack !== (N'(1) << exp)) begin
                failures++;
                $display("[TB] FAIL fair_job%0d: got=%b id=%0d data=%h ack=%b, required 1 %0d 004 %b",
                         j, got, rsp_id, rsp_data, ack, exp, N'(1) << exp);
            end
            if (j > 0) begin
                checks++;
                if (low < 1) begin
                    failures++;
                    $display("[TB] FAIL fair_gap%0d: start-low cycles=%0d, required >=1", j, low);
                end
            end
        end
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timeout();
        bit got;
        int cyc, low;
        logic [31:0] w;
        doReset();
        unitEnable     = 1'b0;
        req_data[31:0] = $urandom;
        req            = 4'b0001;
        waitStart(10, got);
        waitRsp(200, got, cyc, low);
        checks++;
        if (!got || cyc != 64) begin
            failures++;
            $display("[TB] FAIL timeout_latency: got=%b cycles=%0d, required 1 64", got, cyc);
        end
        checks++;
        if (rsp_err !== 1'b1 || rsp_data !== 10'h000 || timeout_err !== 1'b1 || rsp_id !== 2'd0 || ack !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL timeout_rsp: err=%b data=%h terr=%b id=%0d ack=%b, required 1 000 1 0 0001",
                     rsp_err, rsp_data, timeout_err, rsp_id, ack);
        end
        req        = '0;
        unitEnable = 1'b1;
        w          = $urandom;
        req_data[63:32] = w;
        req        = 4'b0010;
        waitRsp(50, got, cyc, low);
        checks++;
        if (!got || rsp_err !== 1'b0 || rsp_data !== byteSum(w) || rsp_id !== 2'd1 || timeout_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL timeout_recover: got=%b err=%b data=%h id=%0d terr=%b, required 1 0 %h 1 1",
                     got, rsp_err, rsp_data, rsp_id, timeout_err, byteSum(w));
        end
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_boundary();
        bit got;
        bit stray;
        int cyc, low;
        logic [31:0] w;
        doReset();
        unitLatency    = 64;
        w              = $urandom;
        req_data[31:0] = w;
        req            = 4'b0001;
        waitStart(10, got);
        waitRsp(200, got, cyc, low);
        checks++;
        if (!got || cyc != 64 || rsp_err !== 1'b0 || timeout_err !== 1'b0 || rsp_data !== byteSum(w)) begin
            failures++;
            $display("[TB] FAIL limit_cycle_valid: got=%b cycles=%0d err=%b terr=%b data=%h, required 1 64 0 0 %h",
                     got, cyc, rsp_err, timeout_err, rsp_data, byteSum(w));
        end
        req         = '0;
        unitLatency = 3;
        repeat (4) @(negedge clk);
        idlePulse = 1'b1;
        stray     = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid || busy || ack != '0) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            failures++;
            $display("[TB] FAIL idle_valid_ignored: response or busy seen=%b, required 0", stray);
        end
    endtask

    task automatic test_reset_mid_run();
        bit got;
        int cyc, low;
        doReset();
        unitEnable     = 1'b0;
        req_data[31:0] = $urandom;
        req            = 4'b0001;
        waitStart(10, got);
        repeat (3) @(negedge clk);
        #2;
        async_reset = 1'b1;
        #1;
        checks++;
        if (sum_start !== 1'b0 || busy !== 1'b0 || ack !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL async_abort: start=%b busy=%b ack=%b, required 0 0 0000", sum_start, busy, ack);
        end
        @(negedge clk);
        checks++;
        if (ack !== 4'b0000 || rsp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_no_ack: ack=%b rv=%b, required 0000 0", ack, rsp_valid);
        end
        req         = 4'b0011;
        unitEnable  = 1'b1;
        async_reset = 1'b0;
        waitRsp(50, got, cyc, low);
        checks++;
        if (!got || rsp_id !== 2'd0 || ack !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL pointer_reset: got=%b id=%0d ack=%b, required 1 0 0001", got, rsp_id, ack);
        end
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        bit got;
        int cyc, low;
        int modelLast;
        int win;
        logic [N-1:0] mask;
        logic [31:0]  words[N];
        doReset();
        modelLast = N - 1;
        for (int j = 0; j < 30; j++) begin
            mask        = N'($urandom_range(1, (1 << N) - 1));
            unitLatency = $urandom_range(1, 8);
            for (int i = 0; i < N; i++) begin
                words[i]             = $urandom;
                req_data[32*i +: 32] = words[i];
            end
            req = mask;
            win = -1;
            for (int k = 1; k <= N; k++) begin
                if (win < 0 && mask[(modelLast + k) % N]) win = (modelLast + k) % N;
            end
            waitStart(10, got);
            for (int i = 0; i < N; i++) req_data[32*i +: 32] = $urandom;
            waitRsp(50, got, cyc, low);
            checks++;
            if (!got || rsp_id !== IW'(win) || rsp_data !== byteSum(words[win]) || rsp_err !== 1'b0 || ack !== (N'(1) << win)) begin
                failures++;
                $display("[TB] FAIL random_job%0d: got=%b id=%0d data=%h err=%b ack=%b, required 1 %0d %h 0 %b",
                         j, got, rsp_id, rsp_data, rsp_err, ack, win, byteSum(words[win]), N'(1) << win);
            end
            modelLast = win;
        end
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    // Test sequence.
    initial begin
        async_reset = 1'b1;
        req         = '0;
        req_data    = '0;
        test_reset();
        test_single_job();
        test_max_value();
        test_fairness();
        test_timeout();
        test_boundary();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sum_unit_arbiter.md
Name: sum_unit_arbiter

Overview:
Shares one four-byte-sum unit among NUM_REQ requesters. The sum unit adds the four 8-bit bytes of a 32-bit word into a 10-bit result. The block grants one requester at a time in round-robin order and drives the unit's start/data handshake. It returns the result tagged with the requester id, and flags a unit that never answers. It sits between the client blocks and the sum datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, requester id width, equal to clog2(NUM_REQ)
TIMEOUT_CYCLES, 64, cycles in RUN without sum_valid before the request is aborted

Ports:
clk  in  1  clock, rising edge
async_reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester request level
req_data  in  32*NUM_REQ  word for requester i at bits [32i+31:32i]
ack  out  NUM_REQ  one-cycle pulse to the served requester
rsp_valid  out  1  one-cycle response strobe
rsp_id  out  ID_W  id of the served requester
rsp_data  out  10  sum result; 0 on timeout
rsp_err  out  1  high with rsp_valid when the request timed out
sum_start  out  1  start level to the sum unit
sum_data  out  32  operand word to the sum unit
sum_valid  in  1  result-valid from the sum unit
sum_result  in  10  result from the sum unit
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky timeout flag, cleared only by reset

Behaviour:
- Reset values, applied asynchronously:
  - state=IDLE
  - ack=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0
  - sum_start=0, sum_data=0, busy=0, timeout_err=0
  - rr pointer (last granted) = NUM_REQ-1, so requester 0 wins first
- All outputs are registered.
- FSM states: IDLE, RUN, RESP, GAP.
- IDLE, with req != 0:
  - Search starts at (last+1) mod NUM_REQ and wraps. The first set bit wins.
  - Latch the winner's id and req_data word. Update last to the winner.
  - sum_start<=1 and sum_data<=latched word on the same edge. Timeout counter<=0. Go to RUN.
- RUN:
  - sum_start and sum_data stay stable. The counter increments every cycle.
  - If sum_valid=1: capture sum_result into rsp_data, rsp_err<=0, go to RESP.
  - Else, if the counter reaches TIMEOUT_CYCLES-1: rsp_data<=0, rsp_err<=1, timeout_err<=1, go to RESP.
  - sum_valid in the same cycle as the counter limit: sum_valid wins (no error).
- Entering RESP:
  - sum_start<=0. rsp_valid<=1 and ack[id]<=1 for exactly one cycle. rsp_id=latched id.
  - RESP always goes to GAP.
- GAP:
  - One idle cycle with sum_start=0, so the unit sees a start low between jobs. Then go to IDLE.
  - rsp_data, rsp_id and rsp_err hold until the next response.
- Latency: req seen in IDLE at edge n gives sum_start=1 after edge n. If the unit raises sum_valid k cycles later, rsp_valid and ack follow one cycle after sum_valid is sampled.
- Throughput: minimum 4 cycles per job plus unit latency. Back-to-back grants to different requesters rotate strictly.
- Requester rules:
  - Hold req until ack.
  - req_data is sampled only at grant; later changes are ignored.
  - req dropped before grant removes that requester from arbitration. req dropped after grant has no effect; the job completes and ack still pulses.
  - req still high the cycle after ack counts as a new request.
- sum_valid outside RUN is ignored.
- Reset asserted mid-job: everything returns to reset values immediately and sum_start drops asynchronously. No ack is issued for the aborted job.

Test Plan:
1. Single job: reset, then req=4'b0001, req_data[31:0]=32'h0302_0201, model unit answers 3 cycles after start -> sum_data=32'h0302_0201 while sum_start=1; rsp_valid with rsp_id=0, rsp_data=10'h008, rsp_err=0; ack=4'b0001 for one cycle.
2. Max value: requester 2 word 32'hFFFF_FFFF -> rsp_data=10'h3FC, rsp_id=2.
3. Fairness: req=4'b1111 held, all words 32'h0101_0101 -> grant order 0,1,2,3,0; each rsp_data=10'h004; sum_start low for ≥1 cycle between jobs.
4. Timeout: unit never asserts sum_valid, TIMEOUT_CYCLES=64 -> rsp_valid exactly 64 cycles after sum_start rises; rsp_err=1, rsp_data=0, timeout_err stays 1; next request is served normally.
5. Boundary: sum_valid arrives on the timeout-limit cycle -> normal response, rsp_err=0, timeout_err=0. A sum_valid pulse in IDLE is ignored (no rsp_valid).
6. Reset mid-RUN: assert async_reset between clock edges -> sum_start, busy and ack go 0 immediately; after release, req=4'b0001 is granted first (pointer reset).
